// File: rtl/ocr_pkg.sv
// Shared constants and FSM state type for the frame_mean datapath.
package ocr_pkg;

  localparam int unsigned VAL_W    = 16;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned RCP_W    = 17;
  localparam int unsigned SUM_W    = 24;
  localparam int unsigned RCP_FRAC = 16;
  localparam int unsigned PROD_W   = SUM_W + RCP_W;

  typedef enum logic [1:0] {StAcc, StLookup, StMul, StDone} frameStateT;

endpackage

// File: rtl/seq_mul_24x17.sv
// Sequential shift-add multiplier: SUM_W x RCP_W unsigned, one multiplier bit per cycle.
module seq_mul_24x17
  import ocr_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SUM_W-1:0]  a,
  input  logic [RCP_W-1:0]  b,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  localparam logic [4:0] LastStep = 5'(RCP_W - 1);

  logic [PROD_W-1:0] mcandQ, mcandD;
  logic [PROD_W-1:0] prodQ, prodD;
  logic [RCP_W-1:0]  mplierQ, mplierD;
  logic [4:0]        stepQ, stepD;
  logic              busyQ, busyD;

  always_comb begin
    mcandD  = mcandQ;
    prodD   = prodQ;
    mplierD = mplierQ;
    stepD   = stepQ;
    busyD   = busyQ;
    if (start) begin
      mcandD  = PROD_W'(a);
      mplierD = b;
      prodD   = '0;
      stepD   = '0;
      busyD   = 1'b1;
    end else if (busyQ) begin
      if (mplierQ[0]) begin
        prodD = prodQ + mcandQ;
      end
      mcandD  = mcandQ << 1;
      mplierD = mplierQ >> 1;
      stepD   = stepQ + 5'd1;
      if (stepQ == LastStep) begin
        busyD = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcandQ  <= '0;
      prodQ   <= '0;
      mplierQ <= '0;
      stepQ   <= '0;
      busyQ   <= 1'b0;
    end else begin
      mcandQ  <= mcandD;
      prodQ   <= prodD;
      mplierQ <= mplierD;
      stepQ   <= stepD;
      busyQ   <= busyD;
    end
  end

  // High during the cycle whose closing edge retires the last bit; product is final after it.
  assign done    = busyQ && (stepQ == LastStep);
  assign product = prodQ;

endmodule

// File: rtl/frame_mean.sv
// Frame mean: accumulates samples, multiplies the sum by an external 1/N, presents the mean.
// Define FRAME_MEAN_ROUND_EN to round half up instead of truncating.
module frame_mean
  import ocr_pkg::*;
#(
  parameter int unsigned VAL_W = ocr_pkg::VAL_W,
  parameter int unsigned CNT_W = ocr_pkg::CNT_W,
  parameter int unsigned RCP_W = ocr_pkg::RCP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [VAL_W-1:0] s_data,
  input  logic             s_last,
  output logic [CNT_W-1:0] rcp_n,
  input  logic [RCP_W-1:0] rcp_val,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [VAL_W-1:0] m_mean,
  output logic             m_empty,
  output logic             m_ovf
);

  frameStateT        stateQ, stateD;
  logic [SUM_W-1:0]  sumQ, sumD;
  logic [CNT_W-1:0]  cntQ, cntD;
  logic              ovfQ, ovfD;
  logic              mulStart, mulDone;
  logic [PROD_W-1:0] product, prodAdj;

  always_comb begin
    stateD   = stateQ;
    sumD     = sumQ;
    cntD     = cntQ;
    ovfD     = ovfQ;
    mulStart = 1'b0;
    unique case (stateQ)
      StAcc: begin
        if (s_valid) begin
          if (&cntQ) begin
            ovfD = 1'b1;
          end else begin
            sumD = sumQ + SUM_W'(s_data);
            cntD = cntQ + CNT_W'(1);
          end
        end
        // s_last closes the frame with or without an accompanying sample.
        if (s_last) begin
          stateD = StLookup;
        end
      end
      StLookup: begin
        if (cntQ == '0) begin
          stateD = StDone;
        end else begin
          mulStart = 1'b1;
          stateD   = StMul;
        end
      end
      StMul: begin
        if (mulDone) begin
          stateD = StDone;
        end
      end
      StDone: begin
        if (m_ready) begin
          stateD = StAcc;
          sumD   = '0;
          cntD   = '0;
          ovfD   = 1'b0;
        end
      end
      default: stateD = StAcc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= StAcc;
      sumQ   <= '0;
      cntQ   <= '0;
      ovfQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      sumQ   <= sumD;
      cntQ   <= cntD;
      ovfQ   <= ovfD;
    end
  end

  // The multiplier captures rcp_val on the LOOKUP->MUL edge.
  seq_mul_24x17 u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mulStart),
    .a       (sumQ),
    .b       (rcp_val),
    .done    (mulDone),
    .product (product)
  );

`ifdef FRAME_MEAN_ROUND_EN
  assign prodAdj = product + PROD_W'(1 << (RCP_FRAC - 1));
`else
  assign prodAdj = product;
`endif

  assign s_ready = (stateQ == StAcc);
  assign m_valid = (stateQ == StDone);
  assign m_empty = m_valid && (cntQ == '0);
  assign m_ovf   = m_valid && ovfQ;
  assign rcp_n   = cntQ;
  assign m_mean  = (m_valid && !m_empty) ? prodAdj[RCP_FRAC +: VAL_W] : '0;

endmodule

// File: tb/tb_frame_mean.sv
// Randomized bench for frame_mean with a cycle-level behavioural model and directed pins.
module tb_frame_mean;

  localparam int unsigned VAL_W = 16;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned RCP_W = 17;
`ifdef FRAME_MEAN_ROUND_EN
  localparam bit Rnd = 1'b1;
`else
  localparam bit Rnd = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             s_valid = 1'b0;
  logic             s_last = 1'b0;
  logic             m_ready = 1'b0;
  logic [VAL_W-1:0] s_data = '0;
  logic             s_ready, m_valid, m_empty, m_ovf;
  logic [CNT_W-1:0] rcp_n;
  logic [RCP_W-1:0] rcp_val;
  logic [VAL_W-1:0] m_mean;

  int     nChk = 0;
  int     nBad = 0;
  longint cyc = 0;
  int unsigned frm[$];

  // Model state: samples seen in the open frame, sum of the kept ones, frame close tracking.
  int     mLen = 0;
  longint mSum = 0;
  bit     mBusy = 1'b0;
  longint mClose = 0;
  int     mLat = 0;

  frame_mean dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .rcp_n   (rcp_n),
    .rcp_val (rcp_val),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_mean  (m_mean),
    .m_empty (m_empty),
    .m_ovf   (m_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External reciprocal lookup: floor(65536/N).
  always_comb rcp_val = (rcp_n == '0) ? '0 : RCP_W'(32'd65536 / 32'(rcp_n));

  task automatic chk(input string name, input longint act, input longint exp);
    nChk++;
    if (act != exp) begin
      nBad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint expMeanOf(input longint sum, input int n);
    longint p;
    if (n == 0) return 0;
    p = sum * (65536 / n);
    if (Rnd) p = p + 32768;
    return (p >> 16) & 65535;
  endfunction

  initial begin : compare
    int n;
    bit ev;
    forever begin
      @(negedge clk);
      n = (mLen > 255) ? 255 : mLen;
      if (!rst_n) begin
        chk("rst s_ready", longint'(s_ready), 1);
        chk("rst m_valid", longint'(m_valid), 0);
        chk("rst m_mean", longint'(m_mean), 0);
        chk("rst m_empty", longint'(m_empty), 0);
        chk("rst m_ovf", longint'(m_ovf), 0);
        chk("rst rcp_n", longint'(rcp_n), 0);
        mLen = 0;
        mSum = 0;
        mBusy = 1'b0;
      end else begin
        ev = mBusy && (cyc >= mClose + mLat);
        chk("s_ready", longint'(s_ready), longint'(!mBusy));
        chk("m_valid", longint'(m_valid), longint'(ev));
        chk("rcp_n", longint'(rcp_n), n);
        if (ev) begin
          chk("m_mean", longint'(m_mean), expMeanOf(mSum, n));
          chk("m_empty", longint'(m_empty), longint'(n == 0));
          chk("m_ovf", longint'(m_ovf), longint'(mLen > 255));
        end
        if (!mBusy) begin
          if (s_valid) begin
            if (mLen < 255) mSum = mSum + longint'(s_data);
            mLen++;
          end
          if (s_last) begin
            mBusy = 1'b1;
            mClose = cyc + 1;
            mLat = (mLen == 0) ? 1 : 18;
          end
        end else if (ev && m_ready) begin
          mBusy = 1'b0;
          mLen = 0;
          mSum = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk(input bit en);
    if (en) begin
      s_valid = 1'($urandom);
      s_last  = 1'($urandom);
      s_data  = VAL_W'($urandom);
    end
  endtask

  // Drives frm as one frame; returns just after the s_last acceptance edge.
  task automatic sendFrame(input bit lastWithData, input int gapPct);
    for (int i = 0; i < frm.size(); i++) begin
      while (int'($urandom_range(99)) < gapPct) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        tick();
      end
      s_valid = 1'b1;
      s_data  = VAL_W'(frm[i]);
      s_last  = lastWithData && (i == frm.size() - 1);
      tick();
    end
    if (!lastWithData || frm.size() == 0) begin
      s_valid = 1'b0;
      s_last  = 1'b1;
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Edge count with the acceptance edge as edge 1; bounded.
  task automatic waitValid(input bit noise, output int edges);
    edges = 1;
    while (!m_valid && edges < 40) begin
      junk(noise);
      tick();
      edges++;
    end
  endtask

  task automatic finishFrame(input int hold, input bit noise);
    for (int i = 0; i < hold; i++) begin
      junk(noise);
      tick();
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic directed(input string name, input int expLat, input int expMean,
                          input int expN, input bit expOvf, input int hold);
    int lat;
    sendFrame(1'b1, 0);
    waitValid(1'b0, lat);
    chk({name, " latency"}, lat, expLat);
    chk({name, " mean"}, longint'(m_mean), expMean);
    chk({name, " rcp_n"}, longint'(rcp_n), expN);
    chk({name, " ovf"}, longint'(m_ovf), longint'(expOvf));
    chk({name, " empty"}, longint'(m_empty), longint'(expN == 0));
    for (int i = 0; i < hold; i++) tick();
    if (hold > 0) begin
      chk({name, " held mean"}, longint'(m_mean), expMean);
      chk({name, " held s_ready"}, longint'(s_ready), 0);
    end
    finishFrame(0, 1'b0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, nChk=%0d", nChk);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lat;
    int len;
    bit lwd;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    frm = '{10, 20, 30, 40};
    directed("avg4", 19, 25, 4, 1'b0, 0);
    frm = '{2, 2, 1};
    directed("221", 19, Rnd ? 2 : 1, 3, 1'b0, 0);
    frm.delete();
    for (int i = 0; i < 300; i++) frm.push_back(7);
    directed("ovf300", 19, Rnd ? 7 : 6, 255, 1'b1, 0);
    frm.delete();
    directed("empty", 2, 0, 0, 1'b0, 0);
    frm = '{65535};
    directed("max", 19, 65535, 1, 1'b0, 10);

    // Abandon a frame mid-multiply.
    frm = '{1, 2, 3};
    sendFrame(1'b1, 0);
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst m_valid", longint'(m_valid), 0);
    chk("midrst s_ready", longint'(s_ready), 1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    chk("postrst m_valid", longint'(m_valid), 0);
    frm = '{5, 5};
    directed("postrst", 19, 5, 2, 1'b0, 0);

    for (int f = 0; f < 40; f++) begin
      len = ($urandom_range(9) == 0) ? int'($urandom_range(256, 290)) : int'($urandom_range(0, 12));
      frm.delete();
      for (int i = 0; i < len; i++) begin
        frm.push_back(($urandom_range(3) == 0) ? $urandom_range(65000, 65535) : $urandom_range(0, 65535));
      end
      lwd = 1'($urandom);
      sendFrame(lwd, 25);
      waitValid(1'b1, lat);
      chk("rand latency", lat, (len == 0) ? 2 : 19);
      finishFrame(int'($urandom_range(0, 4)), 1'b1);
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nChk, nBad);
    $finish;
  end

endmodule
